// File: rtl/adc0808_pkg.sv
// Shared definitions for the ADC0808 emulator: state encoding, default
// timing constants and the reset value of the per-channel data patterns.
package adc0808_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    EOC_DLY = 2'd2,
    CONVERT = 2'd3
  } adc_state_t;

  localparam int DEF_CONV_CYCLES = 64;
  localparam int DEF_EOC_DELAY   = 2;

  // Each channel starts from its own index in the top three bits
  function automatic logic [7:0] pattern_seed(input logic [2:0] ch);
    return {ch, 5'b00000};
  endfunction

endpackage

// File: rtl/adc_edge_det.sv
// Rise/fall detector for a CLK-synchronous strobe, comparing the input
// with its value from the previous clock.
module adc_edge_det (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic din_q_r;

  // Previous-cycle copy of the strobe
  always_ff @(posedge CLK) begin
    if (RST) begin
      din_q_r <= 1'b0;
    end else begin
      din_q_r <= din;
    end
  end

  assign rise = din & ~din_q_r;
  assign fall = ~din & din_q_r;

endmodule

// File: rtl/adc0808_emulator.sv
// Cycle-level emulation of an ADC0808 converter: ALE/START/OE handshake,
// EOC timing, and a self-incrementing result pattern per channel.
module adc0808_emulator
  import adc0808_pkg::*;
#(
  parameter int CONV_CYCLES = DEF_CONV_CYCLES,
  parameter int EOC_DELAY   = DEF_EOC_DELAY
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ALE,
  input  logic       START,
  input  logic       OE,
  input  logic [2:0] ADD,
  output logic       EOC,
  output logic [7:0] DATA,
  output logic       DATA_EN,
  output logic       BUSY,
  output logic [7:0] CONV_CNT
);

  localparam logic [7:0] CONV_LAST = 8'(CONV_CYCLES - 1);
  localparam logic [3:0] DLY_LAST  = 4'(EOC_DELAY - 1);

  logic       ale_rise_s;
  logic       ale_fall_unused_s;
  logic       start_rise_s;
  logic       start_fall_s;
  logic       oe_rise_s;
  logic       oe_fall_s;

  adc_state_t state_r;
  logic       eoc_r;
  logic       busy_r;
  logic       data_en_r;
  logic [2:0] addr_q;
  logic [2:0] ch_r;
  logic [3:0] dly_cnt_r;
  logic [7:0] cyc_cnt_r;
  logic [7:0] latch_r;
  logic [7:0] done_cnt_r;
  logic [7:0] pattern_r [8];

  adc_edge_det u_ale_edge (
    .CLK  (CLK),
    .RST  (RST),
    .din  (ALE),
    .rise (ale_rise_s),
    .fall (ale_fall_unused_s)
  );

  adc_edge_det u_start_edge (
    .CLK  (CLK),
    .RST  (RST),
    .din  (START),
    .rise (start_rise_s),
    .fall (start_fall_s)
  );

  adc_edge_det u_oe_edge (
    .CLK  (CLK),
    .RST  (RST),
    .din  (OE),
    .rise (oe_rise_s),
    .fall (oe_fall_s)
  );

  // Address latch, open in every state on an ALE rise
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q <= 3'd0;
    end else if (ale_rise_s) begin
      addr_q <= ADD;
    end else begin
      addr_q <= addr_q;
    end
  end

  // Read-strobe follower; tracks OE one clock late, independent of the FSM
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_en_r <= 1'b0;
    end else if (oe_rise_s) begin
      data_en_r <= 1'b1;
    end else if (oe_fall_s) begin
      data_en_r <= 1'b0;
    end else begin
      data_en_r <= data_en_r;
    end
  end

  // Conversion state machine with result/pattern update on the last CONVERT clock
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= IDLE;
      eoc_r      <= 1'b1;
      busy_r     <= 1'b0;
      ch_r       <= 3'd0;
      dly_cnt_r  <= 4'd0;
      cyc_cnt_r  <= 8'd0;
      latch_r    <= 8'h00;
      done_cnt_r <= 8'h00;
      for (int n = 0; n < 8; n++) begin
        pattern_r[n] <= pattern_seed(3'(n));
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (start_rise_s) begin
            state_r <= ARMED;
            busy_r  <= 1'b1;
          end
        end
        ARMED: begin
          if (start_fall_s) begin
            state_r   <= EOC_DLY;
            dly_cnt_r <= 4'd0;
          end
        end
        EOC_DLY: begin
          if (start_rise_s) begin
            state_r <= ARMED;
          end else if (dly_cnt_r == DLY_LAST) begin
            state_r   <= CONVERT;
            eoc_r     <= 1'b0;
            cyc_cnt_r <= 8'd0;
            ch_r      <= addr_q;
          end else begin
            dly_cnt_r <= dly_cnt_r + 4'd1;
          end
        end
        CONVERT: begin
          // A new START aborts without touching results or counters
          if (start_rise_s) begin
            state_r <= ARMED;
            eoc_r   <= 1'b1;
          end else if (cyc_cnt_r == CONV_LAST) begin
            state_r          <= IDLE;
            eoc_r            <= 1'b1;
            busy_r           <= 1'b0;
            latch_r          <= pattern_r[ch_r];
            pattern_r[ch_r]  <= pattern_r[ch_r] + 8'd1;
            done_cnt_r       <= done_cnt_r + 8'd1;
          end else begin
            cyc_cnt_r <= cyc_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          eoc_r   <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign EOC      = eoc_r;
  assign BUSY     = busy_r;
  assign DATA_EN  = data_en_r;
  assign DATA     = latch_r & {8{data_en_r}};
  assign CONV_CNT = done_cnt_r;

endmodule

// File: tb/tb_adc0808_emulator.sv
// Directed bench for adc0808_emulator: handshake timing, pattern sequencing,
// abort, wrap, address re-latch and mid-conversion reset.
module tb_adc0808_emulator;

  logic       CLK;
  logic       RST;
  logic       ALE;
  logic       START;
  logic       OE;
  logic [2:0] ADD;
  logic       EOC;
  logic [7:0] DATA;
  logic       DATA_EN;
  logic       BUSY;
  logic [7:0] CONV_CNT;

  int errors_cnt = 0;
  int checks_cnt = 0;

  adc0808_emulator dut (
    .CLK      (CLK),
    .RST      (RST),
    .ALE      (ALE),
    .START    (START),
    .OE       (OE),
    .ADD      (ADD),
    .EOC      (EOC),
    .DATA     (DATA),
    .DATA_EN  (DATA_EN),
    .BUSY     (BUSY),
    .CONV_CNT (CONV_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step(2);
    RST = 1'b0;
    step(1);
  endtask

  task automatic latch_addr(input logic [2:0] ch);
    ADD = ch;
    ALE = 1'b1;
    step(1);
    ALE = 1'b0;
    step(1);
  endtask

  // Runs out the EOC-low phase, then strobes OE to read the result
  task automatic finish_conv(output int low_cnt, output logic [7:0] early, output logic [7:0] rd);
    low_cnt = 0;
    while (EOC == 1'b0 && low_cnt < 300) begin
      low_cnt++;
      step(1);
    end
    early = DATA;
    OE = 1'b1;
    step(1);
    rd = DATA;
    OE = 1'b0;
    step(1);
  endtask

  // Called right after START has been dropped
  task automatic wait_conv(input string tag, input bit timing,
                           output logic [7:0] early, output logic [7:0] rd);
    int low_cnt;
    step(2);
    if (timing) chk({tag, "_eoc_dly"}, EOC, 1'b1);
    step(1);
    if (timing) chk({tag, "_eoc_fall"}, EOC, 1'b0);
    finish_conv(low_cnt, early, rd);
    if (timing || low_cnt >= 300) chk({tag, "_low_clks"}, low_cnt, 32'd64);
  endtask

  task automatic run_conv(input string tag, input bit timing,
                          output logic [7:0] early, output logic [7:0] rd);
    START = 1'b1;
    step(1);
    START = 1'b0;
    wait_conv(tag, timing, early, rd);
  endtask

  task automatic conv(input string tag, input logic [2:0] ch, input bit timing, output logic [7:0] rd);
    logic [7:0] early;
    latch_addr(ch);
    run_conv(tag, timing, early, rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic [7:0] early;
    int         low_cnt;

    RST = 1'b0; ALE = 1'b0; START = 1'b0; OE = 1'b0; ADD = 3'd0;
    step(1);
    do_reset();
    chk("rst_eoc", EOC, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_data_en", DATA_EN, 1'b0);
    chk("rst_data", DATA, 8'h00);
    chk("rst_cnt", CONV_CNT, 8'h00);

    // First conversion on channel 3 with full timing checks
    latch_addr(3'd3);
    START = 1'b1;
    step(1);
    chk("armed_busy", BUSY, 1'b1);
    START = 1'b0;
    wait_conv("c3a", 1'b1, early, rd);
    chk("c3a_data", rd, 8'h60);
    chk("c3a_cnt", CONV_CNT, 8'h01);
    chk("c3a_busy", BUSY, 1'b0);

    conv("c3b", 3'd3, 1'b1, rd);
    chk("c3b_data", rd, 8'h61);
    conv("c0", 3'd0, 1'b1, rd);
    chk("c0_data", rd, 8'h00);
    chk("c0_cnt", CONV_CNT, 8'h03);

    // Abort 10 clocks into CONVERT, OE held high throughout
    latch_addr(3'd3);
    OE = 1'b1;
    START = 1'b1;
    step(1);
    START = 1'b0;
    step(3);
    chk("ab_convert", EOC, 1'b0);
    step(10);
    START = 1'b1;
    step(1);
    chk("ab_eoc", EOC, 1'b1);
    chk("ab_busy", BUSY, 1'b1);
    chk("ab_data", DATA, 8'h00);
    chk("ab_cnt", CONV_CNT, 8'h03);
    START = 1'b0;
    step(2);
    chk("ab_re_dly", EOC, 1'b1);
    step(1);
    chk("ab_re_fall", EOC, 1'b0);
    finish_conv(low_cnt, early, rd);
    chk("ab_re_low", low_cnt, 32'd64);
    chk("ab_oe_held", early, 8'h62);
    chk("ab_re_data", rd, 8'h62);
    chk("ab_re_cnt", CONV_CNT, 8'h04);

    // 33 conversions on channel 7 from reset: E0..FF then wrap to 00
    do_reset();
    for (int i = 0; i < 32; i++) begin
      conv("c7", 3'd7, 1'b0, rd);
    end
    chk("c7_last", rd, 8'hFF);
    conv("c7w", 3'd7, 1'b0, rd);
    chk("c7_wrap", rd, 8'h00);
    chk("c7_cnt", CONV_CNT, 8'h21);

    // Re-latch address to 5 during a channel 2 conversion
    latch_addr(3'd2);
    START = 1'b1;
    step(1);
    START = 1'b0;
    step(3);
    chk("al_convert", EOC, 1'b0);
    ADD = 3'd5;
    ALE = 1'b1;
    step(1);
    ALE = 1'b0;
    step(1);
    finish_conv(low_cnt, early, rd);
    chk("al_low", low_cnt, 32'd62);
    chk("al_ch2", rd, 8'h40);
    run_conv("al_next", 1'b0, early, rd);
    chk("al_ch5", rd, 8'hA0);

    // Reset in the middle of a conversion
    OE = 1'b1;
    START = 1'b1;
    step(1);
    START = 1'b0;
    step(3 + 10);
    chk("mr_convert", EOC, 1'b0);
    RST = 1'b1;
    step(1);
    chk("mr_eoc", EOC, 1'b1);
    chk("mr_busy", BUSY, 1'b0);
    chk("mr_data_en", DATA_EN, 1'b0);
    chk("mr_data", DATA, 8'h00);
    chk("mr_cnt", CONV_CNT, 8'h00);
    RST = 1'b0;
    OE = 1'b0;
    step(2);
    conv("mr5", 3'd5, 1'b1, rd);
    chk("mr_ch5", rd, 8'hA0);
    conv("mr2", 3'd2, 1'b0, rd);
    chk("mr_ch2", rd, 8'h40);
    conv("mr7", 3'd7, 1'b0, rd);
    chk("mr_ch7", rd, 8'hE0);
    chk("mr_cnt_after", CONV_CNT, 8'h03);

    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end

endmodule
